// File: rtl/rt_test_ctrl.sv
// Real-time test controller: counts cycles while enabled, collects per-channel
// end-of-computation reports and raises done/fail/timeout for the test harness.
module rt_test_ctrl #(
    parameter int NumCh          = 2,
    parameter int TimeoutDefault = 32000,
    parameter int CntW           = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [30:0] exit_code_o
);

    logic                        r_en;
    logic                        r_clr_pend;
    logic                        r_timeout;
    logic                        r_rvalid;
    logic [31:0]                 r_rdata;
    logic [CntW-1:0]             r_tmo_val;
    logic [CntW-1:0]             r_cycles;
    logic [NumCh-1:0]            r_mask;
    logic [NumCh-1:0][30:0]      r_code;

    logic                        w_wr;
    logic [5:0]                  w_word;
    logic                        w_done;
    logic                        w_counting;
    logic                        w_hit;
    logic [NumCh-1:0]            w_eoc_wr;
    logic [NumCh-1:0]            w_code_nz;
    logic [30:0]                 w_exit;
    logic [31:0]                 w_status;
    logic [31:0]                 w_rdata;

    assign gnt_o      = req_i;
    assign w_wr       = req_i & we_i;
    assign w_word     = addr_i[7:2];
    assign w_done     = r_timeout | (&r_mask);
    assign w_counting = r_en & ~w_done;
    assign w_hit      = (r_tmo_val != '0) && (r_cycles == r_tmo_val);

    // First write wins; nothing latches once the test is over or a clear is pending.
    genvar gi;
    generate
        for (gi = 0; gi < NumCh; gi++) begin : g_ch
            assign w_eoc_wr[gi]  = w_wr && (w_word == 6'(4 + gi)) && wdata_i[0]
                                   && !r_mask[gi] && !w_done && !r_clr_pend;
            assign w_code_nz[gi] = r_mask[gi] && (r_code[gi] != '0);
        end
    endgenerate

    always_comb begin
        w_exit = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (w_code_nz[i]) w_exit = r_code[i];
        end
    end

    assign done_o      = w_done;
    assign fail_o      = r_timeout | (|w_code_nz);
    assign timeout_o   = r_timeout;
    assign exit_code_o = w_exit;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;

    always_comb begin
        w_status              = '0;
        w_status[NumCh-1:0]   = r_mask;
        w_status[16]          = r_timeout;
        w_status[17]          = fail_o;
        w_status[18]          = w_done;
        w_rdata               = '0;
        case (w_word)
            6'd0:    w_rdata = {31'd0, r_en};
            6'd1:    w_rdata[CntW-1:0] = r_tmo_val;
            6'd2:    w_rdata[CntW-1:0] = r_cycles;
            6'd3:    w_rdata = w_status;
            default: begin
                for (int i = 0; i < NumCh; i++) begin
                    if (w_word == 6'(4 + i)) w_rdata = {r_code[i], r_mask[i]};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
        end
    end

    // CLR is registered here and acts one cycle after the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en       <= 1'b0;
            r_clr_pend <= 1'b0;
            r_tmo_val  <= CntW'(TimeoutDefault);
        end else begin
            r_clr_pend <= w_wr && (w_word == 6'd0) && wdata_i[1];
            if (w_wr && (w_word == 6'd0)) r_en <= wdata_i[0];
            if (w_wr && (w_word == 6'd1)) r_tmo_val <= wdata_i[CntW-1:0];
        end
    end

    // On the matching cycle the counter holds so it reads back as TIMEOUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else if (r_clr_pend) begin
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else if (w_counting) begin
            if (w_hit) begin
                r_timeout <= 1'b1;
            end else if (r_cycles != '1) begin
                r_cycles <= r_cycles + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask <= '0;
            r_code <= '0;
        end else if (r_clr_pend) begin
            r_mask <= '0;
            r_code <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (w_eoc_wr[i]) begin
                    r_mask[i] <= 1'b1;
                    r_code[i] <= wdata_i[31:1];
                end
            end
        end
    end

endmodule

// File: tb/tb_rt_test_ctrl.sv
// Directed scenarios plus random bus traffic against a behavioural model of the
// test controller's register map and completion rules.
module tb_rt_test_ctrl;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, done, fail, tmo;
    logic [31:0] rdata;
    logic [30:0] exit_code;

    int errors = 0;
    int checks = 0;

    rt_test_ctrl #(.NumCh(NCH), .TimeoutDefault(32000), .CntW(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .done_o(done), .fail_o(fail), .timeout_o(tmo), .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_en;
    bit          m_clr;
    bit          m_tmo;
    logic [31:0] m_to;
    logic [31:0] m_cyc;
    bit   [7:0]  m_mask;
    logic [30:0] m_code [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_en = 0; m_clr = 0; m_tmo = 0; m_to = 32000; m_cyc = 0; m_mask = '0;
        for (int i = 0; i < 8; i++) m_code[i] = '0;
    endtask

    function automatic bit m_done();
        int n = 0;
        for (int i = 0; i < NCH; i++) if (m_mask[i]) n++;
        return m_tmo || (n == NCH);
    endfunction

    function automatic bit m_fail();
        bit f = m_tmo;
        for (int i = 0; i < NCH; i++) if (m_mask[i] && m_code[i] != 0) f = 1;
        return f;
    endfunction

    function automatic logic [30:0] m_exit();
        for (int i = 0; i < NCH; i++) if (m_mask[i] && m_code[i] != 0) return m_code[i];
        return '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int w = int'(a[7:2]);
        logic [31:0] v = '0;
        if (w == 0) v = {31'd0, m_en};
        else if (w == 1) v = m_to;
        else if (w == 2) v = m_cyc;
        else if (w == 3) begin
            for (int i = 0; i < NCH; i++) v[i] = m_mask[i];
            v[16] = m_tmo; v[17] = m_fail(); v[18] = m_done();
        end else if (w >= 4 && w < 4 + NCH) v = {m_code[w-4], m_mask[w-4]};
        return v;
    endfunction

    task automatic m_step(input bit r, input bit wr, input logic [7:0] a, input logic [31:0] d);
        int w = int'(a[7:2]);
        bit dn = m_done();
        bit counting = m_en && !dn;
        bit wen = r && wr;
        if (m_clr) begin
            m_cyc = 0; m_tmo = 0; m_mask = '0;
            for (int i = 0; i < 8; i++) m_code[i] = '0;
        end else begin
            if (counting) begin
                if (m_to != 0 && m_cyc == m_to) m_tmo = 1;
                else if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            end
            if (wen && w >= 4 && w < 4 + NCH && d[0] && !m_mask[w-4] && !dn) begin
                m_mask[w-4] = 1;
                m_code[w-4] = d[31:1];
            end
        end
        m_clr = 0;
        if (wen && w == 0) begin m_en = d[0]; m_clr = d[1]; end
        if (wen && w == 1) m_to = d;
    endtask

    task automatic chk_outs();
        chk("done_o", {31'd0, done}, {31'd0, m_done()});
        chk("fail_o", {31'd0, fail}, {31'd0, m_fail()});
        chk("timeout_o", {31'd0, tmo}, {31'd0, m_tmo});
        chk("exit_code_o", {1'b0, exit_code}, {1'b0, m_exit()});
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        logic [31:0] exp;
        req = 1; we = wr; addr = a; wdata = d;
        exp = wr ? 32'd0 : m_read(a);
        #1;
        chk("gnt_o", {31'd0, gnt}, 32'd1);
        @(posedge clk);
        m_step(1, wr, a, d);
        #1;
        chk("rvalid_o", {31'd0, rvalid}, 32'd1);
        chk(wr ? "wr_rdata" : "rdata", rdata, exp);
        chk_outs();
        rd = rdata;
        $display("%s addr=%02h data=%08h rdata=%08h done=%0b fail=%0b tmo=%0b",
                 wr ? "WR" : "RD", a, d, rdata, done, fail, tmo);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            req = 0; we = 0;
            @(posedge clk);
            m_step(0, 0, 8'h00, 32'd0);
            #1;
            chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
            chk("idle_rdata", rdata, 32'd0);
            chk_outs();
        end
    endtask

    logic [31:0] rd;

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_outs();
        rst = 0;
        idle(2);

        // Scenario 1: both channels pass
        xfer(1, 8'h00, 32'h1, rd);
        xfer(1, 8'h10, 32'h1, rd);
        xfer(1, 8'h14, 32'h1, rd);
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_fail", {31'd0, fail}, 32'd0);
        xfer(0, 8'h0C, 32'd0, rd);
        chk("s1_status", rd, 32'h0004_0003);

        // Scenario 2: channel 1 fails with code 5
        xfer(1, 8'h00, 32'h3, rd);
        idle(1);
        xfer(1, 8'h14, 32'h0B, rd);
        xfer(1, 8'h10, 32'h1, rd);
        chk("s2_done", {31'd0, done}, 32'd1);
        chk("s2_fail", {31'd0, fail}, 32'd1);
        chk("s2_exit", {1'b0, exit_code}, 32'd5);

        // Scenario 3: timeout after 10 counted cycles
        xfer(1, 8'h00, 32'h2, rd);
        idle(1);
        xfer(1, 8'h04, 32'd10, rd);
        xfer(1, 8'h00, 32'h1, rd);
        idle(10);
        chk("s3_no_tmo_yet", {31'd0, tmo}, 32'd0);
        idle(1);
        chk("s3_tmo", {31'd0, tmo}, 32'd1);
        xfer(0, 8'h08, 32'd0, rd);
        chk("s3_cycles", rd, 32'd10);
        idle(5);
        xfer(0, 8'h08, 32'd0, rd);
        chk("s3_frozen", rd, 32'd10);

        // Scenario 4: first write wins; TIMEOUT=0 disables
        xfer(1, 8'h00, 32'h3, rd);
        idle(1);
        xfer(1, 8'h04, 32'd0, rd);
        xfer(1, 8'h10, 32'h1, rd);
        xfer(1, 8'h10, 32'h3, rd);
        xfer(0, 8'h10, 32'd0, rd);
        chk("s4_eoc0", rd, 32'h1);
        idle(100);
        chk("s4_no_tmo", {31'd0, tmo}, 32'd0);

        // Scenario 5: CLR takes effect in the cycle of the last EOC
        xfer(1, 8'h00, 32'h3, rd);
        idle(1);
        xfer(1, 8'h10, 32'h1, rd);
        xfer(1, 8'h00, 32'h3, rd);
        xfer(1, 8'h14, 32'h1, rd);
        chk("s5_done", {31'd0, done}, 32'd0);
        xfer(0, 8'h08, 32'd0, rd);
        chk("s5_cycles", rd, 32'd0);
        xfer(0, 8'h0C, 32'd0, rd);
        chk("s5_status", rd, 32'd0);
        xfer(0, 8'h00, 32'd0, rd);
        chk("s5_en", rd, 32'd1);

        // Unmapped and read-only accesses
        xfer(1, 8'h08, 32'h1234, rd);
        xfer(1, 8'h18, 32'h1, rd);
        xfer(0, 8'h18, 32'd0, rd);
        chk("unmapped_eoc2", rd, 32'd0);
        xfer(0, 8'hFC, 32'd0, rd);
        chk("unmapped_fc", rd, 32'd0);

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            int op = $urandom_range(0, 99);
            logic [31:0] d = $urandom;
            logic [7:0] a;
            if (op < 28) begin
                a = 8'h10 + 8'(4 * $urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) d[31:1] = '0;
                else if ($urandom_range(0, 1) == 0) d[31:4] = '0;
                d[0] = ($urandom_range(0, 4) != 0);
                xfer(1, a, d, rd);
            end else if (op < 48) begin
                a = 8'($urandom_range(0, 255));
                xfer(0, a, 32'd0, rd);
            end else if (op < 56) begin
                d = {30'd0, (m_done() || $urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0)};
                xfer(1, 8'h00, d, rd);
            end else if (op < 62) begin
                xfer(1, 8'h04, 32'($urandom_range(0, 40)), rd);
            end else if (op < 66) begin
                a = {$urandom_range(2, 63) == 2 ? 6'd2 : 6'($urandom_range(2, 63)), 2'($urandom_range(0, 3))};
                if (a[7:2] >= 6'd4 && a[7:2] < 6'd6) a = 8'h0C;
                xfer(1, a, d, rd);
            end else begin
                idle($urandom_range(1, 6));
            end
        end

        // Scenario 6: reset mid-count with a read in flight
        xfer(1, 8'h00, 32'h3, rd);
        idle(1);
        xfer(1, 8'h04, 32'd0, rd);
        idle(4);
        req = 1; we = 0; addr = 8'h08; wdata = '0;
        @(posedge clk);
        #1;
        rst = 1; req = 0;
        m_reset();
        #1;
        chk("s6_rvalid_in_rst", {31'd0, rvalid}, 32'd0);
        chk("s6_rdata_in_rst", rdata, 32'd0);
        chk_outs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        idle(3);
        xfer(0, 8'h04, 32'd0, rd);
        chk("s6_timeout_reg", rd, 32'd32000);
        xfer(0, 8'h00, 32'd0, rd);
        chk("s6_en", rd, 32'd0);
        xfer(0, 8'h08, 32'd0, rd);
        chk("s6_cycles", rd, 32'd0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
